// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: state codes, ALU function selects, flag bit positions.
package alu_pkg;

   localparam int unsigned ALU_DATA_W   = 16;
   localparam int unsigned ALU_FUNSEL_W = 5;
   localparam int unsigned FLAGS_W      = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_FLAGS = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   localparam logic [4:0] FS_ADD16 = 5'b10100;
   localparam logic [4:0] FS_ADC16 = 5'b10101;
   localparam logic [4:0] FS_SUB16 = 5'b10110;
   localparam logic [4:0] FS_AND16 = 5'b10111;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_O = 0;

endpackage

// File: rtl/alu_rr_picker.sv
// Two-way round-robin winner select with an optional sticky lock on one port.
module alu_rr_picker (
   input  logic valid0,
   input  logic valid1,
   input  logic pointer,
   input  logic lock_valid,
   input  logic lock_owner,
   output logic grant0,
   output logic grant1
);

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (lock_valid) begin
         // Locked: the non-owner is starved until the owner drops its lock.
         grant0 = valid0 & ~lock_owner;
         grant1 = valid1 & lock_owner;
      end else if (pointer) begin
         grant1 = valid1;
         grant0 = valid0 & ~valid1;
      end else begin
         grant0 = valid0;
         grant1 = valid1 & ~valid0;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto the shared 16-bit ALU and sequences one flag-writing cycle per op,
// returning the registered result and flags over a valid/ready response handshake.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W   = ALU_DATA_W,
   parameter int unsigned FUNSEL_W = ALU_FUNSEL_W
) (
   input  logic                Clock,
   input  logic                Reset,

   input  logic                ReqValid0,
   output logic                ReqReady0,
   input  logic [FUNSEL_W-1:0] ReqFunSel0,
   input  logic [DATA_W-1:0]   ReqA0,
   input  logic [DATA_W-1:0]   ReqB0,
   input  logic                ReqLock0,

   input  logic                ReqValid1,
   output logic                ReqReady1,
   input  logic [FUNSEL_W-1:0] ReqFunSel1,
   input  logic [DATA_W-1:0]   ReqA1,
   input  logic [DATA_W-1:0]   ReqB1,
   input  logic                ReqLock1,

   output logic                RspValid0,
   input  logic                RspReady0,
   output logic                RspValid1,
   input  logic                RspReady1,
   output logic [DATA_W-1:0]   RspData,
   output logic [FLAGS_W-1:0]  RspFlags,

   output logic [FUNSEL_W-1:0] AluFunSel,
   output logic [DATA_W-1:0]   AluA,
   output logic [DATA_W-1:0]   AluB,
   output logic                AluWF,
   input  logic [DATA_W-1:0]   AluOut,
   input  logic [FLAGS_W-1:0]  AluFlags,

   output logic                Busy
);

   state_t              state_q, state_d;
   logic                ptr_q;
   logic                lock_valid_q;
   logic                lock_owner_q;
   logic                owner_q;
   logic                op_lock_q;
   logic [FUNSEL_W-1:0] op_funsel_q;
   logic [DATA_W-1:0]   op_a_q;
   logic [DATA_W-1:0]   op_b_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic [FLAGS_W-1:0]  rsp_flags_q;

   logic grant0, grant1;
   logic idle, accept, rsp_ready, rsp_done;

   alu_rr_picker u_picker (
      .valid0     (ReqValid0),
      .valid1     (ReqValid1),
      .pointer    (ptr_q),
      .lock_valid (lock_valid_q),
      .lock_owner (lock_owner_q),
      .grant0     (grant0),
      .grant1     (grant1)
   );

   assign idle      = (state_q == ST_IDLE);
   assign ReqReady0 = idle & grant0;
   assign ReqReady1 = idle & grant1;
   assign accept    = ReqReady0 | ReqReady1;
   assign rsp_ready = owner_q ? RspReady1 : RspReady0;
   assign rsp_done  = (state_q == ST_RESP) & rsp_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_FLAGS;
         ST_FLAGS: state_d = ST_RESP;
         ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q      <= ST_IDLE;
         ptr_q        <= 1'b0;
         lock_valid_q <= 1'b0;
         lock_owner_q <= 1'b0;
         owner_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q <= grant1;
         end
         if (rsp_done) begin
            if (op_lock_q) begin
               lock_valid_q <= 1'b1;
               lock_owner_q <= owner_q;
            end else begin
               lock_valid_q <= 1'b0;
               ptr_q        <= ~owner_q;
            end
         end
      end
   end

   // Op registers feed the ALU directly, so its inputs only move on a new grant.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         op_funsel_q <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_lock_q   <= 1'b0;
      end else if (accept) begin
         op_funsel_q <= grant1 ? ReqFunSel1 : ReqFunSel0;
         op_a_q      <= grant1 ? ReqA1 : ReqA0;
         op_b_q      <= grant1 ? ReqB1 : ReqB0;
         op_lock_q   <= grant1 ? ReqLock1 : ReqLock0;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
      end else begin
         if (state_q == ST_ISSUE) rsp_data_q <= AluOut;
         if (state_q == ST_FLAGS) rsp_flags_q <= AluFlags;
      end
   end

   assign AluFunSel = op_funsel_q;
   assign AluA      = op_a_q;
   assign AluB      = op_b_q;
   assign AluWF     = (state_q == ST_ISSUE);
   assign RspValid0 = (state_q == ST_RESP) & ~owner_q;
   assign RspValid1 = (state_q == ST_RESP) & owner_q;
   assign RspData   = rsp_data_q;
   assign RspFlags  = rsp_flags_q;
   assign Busy      = ~idle;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 16-bit ArithmeticLogicUnit. It accepts operation requests (FunSel, A, B) from two requesters: port 0 is the address/fetch unit and port 1 is the execute unit. It grants them round-robin, with an optional lock for multi-op carry chains. For each granted request it drives the ALU for exactly one flag-writing cycle and returns the registered result and flags through a valid/ready response handshake.

## Interface
Parameters:
- DATA_W, 16, operand/result width; fixed to the ALU width.
- FUNSEL_W, 5, ALU function-select width.

Ports:
- Clock  in  1  single system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid0/ReqValid1  in  1  request present on port n.
- ReqReady0/ReqReady1  out  1  port n request accepted this cycle.
- ReqFunSel0/1  in  FUNSEL_W  ALU function for port n.
- ReqA0/1, ReqB0/1  in  DATA_W  operands for port n.
- ReqLock0/1  in  1  keep the grant on port n after this op completes.
- RspValid0/RspValid1  out  1  response available on port n.
- RspReady0/RspReady1  in  1  port n consumes the response.
- RspData  out  DATA_W  registered ALU result; shared by both ports.
- RspFlags  out  4  registered {Z,C,N,O}; bit 3 = Z, bit 0 = O.
- AluFunSel  out  FUNSEL_W  drives ALU FunSel.
- AluA, AluB  out  DATA_W  drive ALU A and B.
- AluWF  out  1  flag-write enable to the ALU.
- AluOut  in  DATA_W  ALU ALUOut.
- AluFlags  in  4  ALU FlagsOut.
- Busy  out  1  state is not IDLE.

## Operation
- The ALU must update FlagsOut only on edges where AluWF=1; integration must guarantee this.
- States: IDLE, ISSUE, FLAGS, RESP.
- IDLE, request acceptance:
  - ReqReadyN is asserted combinationally for the winning valid port only.
  - Handshake is ReqValidN & ReqReadyN.
  - On handshake: latch FunSel/A/B/Lock into op registers, record the owner, go to ISSUE.
- IDLE, winner selection:
  - If a lock is held, only the lock owner may win; the other port waits with ReqReady=0.
  - Otherwise, the port named by the priority pointer wins if valid, else the other port.
- ISSUE:
  - AluFunSel/A/B come from the op registers; AluWF=1.
  - On the edge: capture AluOut into RspData, go to FLAGS.
- FLAGS:
  - AluWF=0; ALU inputs held.
  - On the edge: capture AluFlags into RspFlags, go to RESP.
- RESP:
  - RspValid of the owner = 1; hold until RspReady of the owner.
  - On the handshake edge: return to IDLE.
  - If the latched Lock=1, set the lock to the owner; else clear the lock and set the pointer to the non-owner.
- Outside ISSUE/FLAGS: AluWF=0, and AluFunSel/A/B hold their last values, so the ALU's combinational output does not toggle.
- Requests are not queued. A requester may deassert ReqValid before acceptance without effect. After acceptance, the requester may change its inputs freely.
- Only the owner's RspValid is ever 1. RspData/RspFlags are stable from FLAGS exit until the RESP handshake.

## Timing
- Reset values: state IDLE, pointer=0, lock cleared, RspValid0/1=0, RspData=0, RspFlags=0, AluFunSel=0, AluA=AluB=0, AluWF=0, Busy=0.
- Latency: request handshake at edge t gives RspValid=1 in the cycle after edge t+2.
- Best-case throughput: one op per 4 cycles, with RspReady tied high.
- Simultaneous ReqValid0 & ReqValid1 in IDLE: the pointer decides; the loser is served next unless the winner locks.
- A lock held while the owner has no request stalls the other port indefinitely. This is intended; the requester is responsible for dropping Lock.
- Reset asserted mid-operation:
  - The op is dropped and all outputs return to reset values immediately.
  - No response is issued.
  - ALU flags are not reset by this block.
- Carry-dependent FunSels (ADC 5'b?0101, rotates 5'b?1110/?1111) see the carry left by the previous granted op. The lock guarantees that the previous op belongs to the same requester.

## Structure
- Shared package alu_pkg:
  - state enum;
  - FunSel constants (e.g. ADD16=5'b10100, ADC16=5'b10101, SUB16=5'b10110);
  - flag indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0.
- One sub-module, alu_rr_picker: combinational 2-way winner select from {valid0, valid1, pointer, lock_valid, lock_owner}.
- The FSM, op registers and response registers stay in alu_arbiter.

## Test plan
- Single op: port1 ADD16, A=16'h7FFF, B=16'h0001 -> RspValid1 3 cycles after accept, RspData=16'h8000, RspFlags=4'b0011, RspValid0 stays 0.
- Contention: both valid from reset (pointer=0) -> port0 served first, then port1, order 0,1,0,1 over 4 ops; AluWF high exactly one cycle per op.
- Lock chain: port0 ADD16 (Lock=1) then ADC16 while port1 is valid -> both port0 ops complete before port1 gets ReqReady1.
- Backpressure: RspReady0=0 for 5 cycles -> RspValid0, RspData and RspFlags held constant; no new ReqReady; Busy=1.
- Reset in FLAGS: drop Reset during FLAGS -> all outputs at reset values the same cycle; after release, first grant goes to port0.
- Flag isolation: SUB16 A=B=16'h1234, then hold in RESP for 10 cycles -> RspFlags Z=1, and AluFlags unchanged because AluWF=0.
